eth_decap: RTL and testbench



---
 rtl/eth_decap.sv | 142 ++++++++++++++
 tb/tb_eth_decap.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_decap.sv
// eth_decap: receive-side decapsulator for TLP-over-UDP frames.
// Parses the fixed 48-byte Eth+IPv4+UDP+pad header (6 beats of 64 bits).
// Frames addressed to this node have their payload beats forwarded to a
// FIFO as {tkeep, tdata, tlast, tuser}. All other frames are dropped and
// counted.
// Ports:
//   clk156, sys_rst           clock, synchronous active-high reset
//   s_axis_t*                 AXI-Stream RX beats from the 10G MAC
//   wr_en, din, full          FIFO write side (din = {tkeep, tdata, tlast, tuser})
//   rx_frames, rx_drops       saturating accepted / dropped frame counters
module eth_decap #(
  parameter logic [47:0] eth_addr  = 48'h90_E2_BA_5D_8D_C8,
  parameter logic [31:0] ip_addr   = {8'd192, 8'd168, 8'd1, 8'd122},
  parameter logic [15:0] udp_port  = 16'd3776,
  parameter int          hdr_beats = 6
) (
  input  logic        clk156,
  input  logic        sys_rst,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        wr_en,
  output logic [73:0] din,
  input  logic        full,
  output logic [31:0] rx_frames,
  output logic [31:0] rx_drops
);

  typedef enum logic [1:0] {HDR, DATA, DROP} state_t;

  // Wire byte 0 lands in lane 0 (tdata[7:0]), so big-endian header fields
  // appear byte-swapped when viewed as a little-endian tdata slice.
  localparam logic [47:0] ETH_LANES = {eth_addr[7:0],   eth_addr[15:8],
                                       eth_addr[23:16], eth_addr[31:24],
                                       eth_addr[39:32], eth_addr[47:40]};
  localparam logic [15:0] IP_HI_LANES = {ip_addr[23:16], ip_addr[31:24]};
  localparam logic [15:0] IP_LO_LANES = {ip_addr[7:0],   ip_addr[15:8]};
  localparam logic [15:0] PORT_LANES  = {udp_port[7:0],  udp_port[15:8]};
  localparam logic [2:0]  LAST_HDR    = 3'(hdr_beats - 1);

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_beat_cnt, w_beat_cnt_nxt;
  logic        r_match, w_match_nxt;
  logic        r_wr_en;
  logic [73:0] r_din;
  logic [31:0] r_rx_frames, r_rx_drops;
  logic        w_xfer, w_beat_ok, w_frame_inc, w_drop_inc, w_ready;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign w_ready       = (r_state == DATA) ? !full : 1'b1;
  assign w_xfer        = s_axis_tvalid && w_ready;
  assign s_axis_tready = w_ready;
  assign wr_en         = r_wr_en;
  assign din           = r_din;
  assign rx_frames     = r_rx_frames;
  assign rx_drops      = r_rx_drops;

  // Per-beat header field check, selected by the header beat index.
  always_comb begin
    w_beat_ok = 1'b1;
    case (r_beat_cnt)
      3'd0: w_beat_ok = (s_axis_tdata[47:0] == ETH_LANES) ||
                        (s_axis_tdata[47:0] == 48'hFFFF_FFFF_FFFF);
      3'd1: w_beat_ok = (s_axis_tdata[47:32] == 16'h0008) &&
                        (s_axis_tdata[55:48] == 8'h45);
      3'd2: w_beat_ok = (s_axis_tdata[63:56] == 8'h11);
      3'd3: w_beat_ok = (s_axis_tdata[63:48] == IP_HI_LANES);
      3'd4: w_beat_ok = (s_axis_tdata[15:0] == IP_LO_LANES) &&
                        (s_axis_tdata[47:32] == PORT_LANES);
      default: w_beat_ok = 1'b1;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_match_nxt    = r_match;
    w_frame_inc    = 1'b0;
    w_drop_inc     = 1'b0;
    case (r_state)
      HDR: begin
        if (w_xfer) begin
          if (s_axis_tlast) begin
            // Runt or header-only frame: nothing to forward.
            w_drop_inc     = 1'b1;
            w_beat_cnt_nxt = 3'd0;
            w_match_nxt    = 1'b1;
          end else if (r_beat_cnt == LAST_HDR) begin
            w_beat_cnt_nxt = 3'd0;
            w_match_nxt    = 1'b1;
            w_state_nxt    = (r_match && w_beat_ok) ? DATA : DROP;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + 3'd1;
            w_match_nxt    = r_match && w_beat_ok;
          end
        end
      end
      DATA: begin
        if (w_xfer && s_axis_tlast) begin
          w_frame_inc = 1'b1;
          w_state_nxt = HDR;
        end
      end
      DROP: begin
        if (w_xfer && s_axis_tlast) begin
          w_drop_inc  = 1'b1;
          w_state_nxt = HDR;
        end
      end
      default: w_state_nxt = HDR;
    endcase
  end

  // Stage boundary: accepted payload beat -> registered FIFO write.
  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      r_state     <= HDR;
      r_beat_cnt  <= 3'd0;
      r_match     <= 1'b1;
      r_wr_en     <= 1'b0;
      r_din       <= '0;
      r_rx_frames <= '0;
      r_rx_drops  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_match    <= w_match_nxt;
      r_wr_en    <= (r_state == DATA) && w_xfer;
      if ((r_state == DATA) && w_xfer)
        r_din <= {s_axis_tkeep, s_axis_tdata, s_axis_tlast, s_axis_tuser};
      if (w_frame_inc) r_rx_frames <= sat_inc(r_rx_frames);
      if (w_drop_inc)  r_rx_drops  <= sat_inc(r_rx_drops);
    end
  end

endmodule

// File: tb/tb_eth_decap.sv
`timescale 1ns/1ps
module tb_eth_decap;
  logic        clk156 = 1'b0;
  logic        sys_rst = 1'b1;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic        wr_en;
  logic [73:0] din;
  logic        full = 1'b0;
  logic [31:0] rx_frames, rx_drops;

  localparam logic [47:0] MY_MAC = 48'h90_E2_BA_5D_8D_C8;
  localparam logic [47:0] BCAST  = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [31:0] MY_IP  = {8'd192, 8'd168, 8'd1, 8'd122};

  int errors = 0;
  int checks = 0;
  int n_push = 0;
  int n_wr   = 0;
  logic [31:0] exp_frames = 0;
  logic [31:0] exp_drops  = 0;
  logic [73:0] sb[$];

  always #3.2 clk156 = ~clk156;

  eth_decap dut (
    .clk156(clk156), .sys_rst(sys_rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .wr_en(wr_en), .din(din), .full(full),
    .rx_frames(rx_frames), .rx_drops(rx_drops)
  );

  task automatic check(input string tag, input logic [73:0] obs, input logic [73:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every FIFO write must match the oldest expected word.
  always @(negedge clk156) begin
    if (wr_en === 1'b1) begin
      n_wr++;
      if (sb.size() == 0) begin
        check("unexpected_write", din, 74'h0);
        check("write_with_empty_sb", 74'(sb.size()), 74'd1);
      end else begin
        check("fifo_din", din, sb.pop_front());
      end
    end
  end

  task automatic send(input logic [63:0] d, input logic [7:0] k,
                      input logic l, input logic u, input logic push);
    int n;
    n = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    forever begin
      @(negedge clk156);
      if (s_axis_tready) break;
      n++;
      if (n > 200) begin
        errors++;
        $error("FAIL send_timeout: observed=tready_low expected=accept");
        break;
      end
    end
    @(posedge clk156);
    #1;
    if (push) begin
      sb.push_back({k, d, l, u});
      n_push++;
    end
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (n) @(posedge clk156);
    #1;
  endtask

  // Builds the 48-byte header from the wire layout and sends beats 0..5;
  // last_at >= 0 ends the frame early with tlast on that beat.
  task automatic send_hdr(input logic [47:0] dst, input logic [15:0] etype,
                          input logic [15:0] dport, input int last_at);
    logic [7:0]  h[48];
    logic [63:0] d;
    for (int i = 0; i < 48; i++) h[i] = 8'(i + 8'h30);
    for (int i = 0; i < 6; i++) h[i] = dst[47-8*i -: 8];
    h[12] = etype[15:8]; h[13] = etype[7:0];
    h[14] = 8'h45;
    h[23] = 8'h11;
    h[30] = MY_IP[31:24]; h[31] = MY_IP[23:16];
    h[32] = MY_IP[15:8];  h[33] = MY_IP[7:0];
    h[36] = dport[15:8];  h[37] = dport[7:0];
    for (int b = 0; b < 6; b++) begin
      for (int k = 0; k < 8; k++) d[8*k +: 8] = h[8*b + k];
      send(d, 8'hFF, (b == last_at), 1'b0, 1'b0);
      if (b == last_at) break;
    end
  endtask

  task automatic send_payload(input int n, input logic push, input logic u);
    logic [63:0] d;
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom};
      send(d, (i == n-1) ? 8'h0F : 8'hFF, (i == n-1), (i == n-1) ? u : 1'b0, push);
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_frames"}, 74'(rx_frames), 74'(exp_frames));
    check({tag, "_drops"},  74'(rx_drops),  74'(exp_drops));
  endtask

  initial begin
    logic [63:0] p;
    repeat (3) @(posedge clk156);
    #1;
    sys_rst = 1'b0;
    @(negedge clk156);
    check("rst_wr_en", 74'(wr_en), 74'd0);
    check("rst_din", din, 74'd0);
    check("rst_tready", 74'(s_axis_tready), 74'd1);
    check_counters("rst");
    @(posedge clk156); #1;

    // Matching unicast frame with three payload beats, last one partial.
    send_hdr(MY_MAC, 16'h0800, 16'd3776, -1);
    send_payload(3, 1'b1, 1'b0);
    check("last_wr_en", 74'(wr_en), 74'd1);
    check("last_keep", 74'(din[73:66]), 74'h0F);
    check("last_tlast", 74'(din[1]), 74'd1);
    idle(2);
    check("after_last_wr_en", 74'(wr_en), 74'd0);
    exp_frames = 1;
    check_counters("f1");

    // Wrong UDP port, then a matching frame back to back.
    send_hdr(MY_MAC, 16'h0800, 16'd3777, -1);
    send_payload(3, 1'b0, 1'b0);
    exp_drops = exp_drops + 1;
    send_hdr(MY_MAC, 16'h0800, 16'd3776, -1);
    send_payload(2, 1'b1, 1'b1);
    idle(2);
    exp_frames = exp_frames + 1;
    check_counters("port");

    // Broadcast destination: IPv6 ethertype dropped, IPv4 accepted.
    send_hdr(BCAST, 16'h86DD, 16'd3776, -1);
    send_payload(2, 1'b0, 1'b0);
    idle(1);
    exp_drops = exp_drops + 1;
    check_counters("bc6");
    send_hdr(BCAST, 16'h0800, 16'd3776, -1);
    send_payload(1, 1'b1, 1'b0);
    idle(2);
    exp_frames = exp_frames + 1;
    check_counters("bc4");

    // Runt frame ending on header beat 3, then a frame parsed from beat 0.
    send_hdr(MY_MAC, 16'h0800, 16'd3776, 3);
    idle(2);
    exp_drops = exp_drops + 1;
    check_counters("runt");
    send_hdr(MY_MAC, 16'h0800, 16'd3776, -1);
    send_payload(1, 1'b1, 1'b0);
    idle(2);
    exp_frames = exp_frames + 1;
    check_counters("post_runt");

    // FIFO backpressure for 5 cycles in the middle of the payload.
    send_hdr(MY_MAC, 16'h0800, 16'd3776, -1);
    p = {$urandom, $urandom};
    send(p, 8'hFF, 1'b0, 1'b0, 1'b1);
    s_axis_tdata = {$urandom, $urandom};
    full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk156);
      check("full_tready", 74'(s_axis_tready), 74'd0);
      if (i > 0) check("full_no_write", 74'(wr_en), 74'd0);
      @(posedge clk156); #1;
    end
    full = 1'b0;
    send(s_axis_tdata, 8'hFF, 1'b0, 1'b0, 1'b1);
    send({$urandom, $urandom}, 8'h3F, 1'b1, 1'b0, 1'b1);
    idle(2);
    exp_frames = exp_frames + 1;
    check_counters("full");

    // Reset while payload beat 2 of 4 is on the bus.
    send_hdr(MY_MAC, 16'h0800, 16'd3776, -1);
    send({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0, 1'b1);
    s_axis_tdata = {$urandom, $urandom};
    sys_rst = 1'b1;
    @(posedge clk156); #1;
    sys_rst = 1'b0;
    exp_frames = 0;
    exp_drops  = 0;
    check("rst2_wr_en", 74'(wr_en), 74'd0);
    check("rst2_din", din, 74'd0);
    check_counters("rst2");
    send({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0, 1'b0);
    send({$urandom, $urandom}, 8'h0F, 1'b1, 1'b0, 1'b0);
    idle(2);
    exp_drops = 1;
    check_counters("rst2_tail");
    send_hdr(MY_MAC, 16'h0800, 16'd3776, -1);
    send_payload(2, 1'b1, 1'b0);
    idle(3);
    exp_frames = 1;
    check_counters("rst2_clean");

    check("sb_empty", 74'(sb.size()), 74'd0);
    check("write_count", 74'(n_wr), 74'(n_push));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
